// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and pipeline bubble values.
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0]  BUBBLE_STAT  = SAOK;
    localparam logic [3:0]  BUBBLE_ICODE = NOP;
    localparam logic        BUBBLE_CND   = 1'b0;
    localparam logic [63:0] BUBBLE_VAL   = 64'd0;
    localparam logic [3:0]  BUBBLE_DST   = RNONE;

    function automatic logic mem_reads(input logic [3:0] icode);
        return (icode == MRMOVQ) || (icode == POPQ) || (icode == RET);
    endfunction

    function automatic logic mem_writes(input logic [3:0] icode);
        return (icode == RMMOVQ) || (icode == PUSHQ) || (icode == CALL);
    endfunction

    // popq and ret address the stack through valA; everything else uses valE
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == POPQ) || (icode == RET);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed data memory: combinational little-endian 8-byte read,
// synchronous 8-byte write, and an out-of-range detector that blocks the access.
module data_memory #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              access,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wr_data,
    output logic [63:0]       rd_data,
    output logic              dmem_error
);
    localparam int IDX_W = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 8);

    logic [7:0]       mem [MEM_BYTES];
    logic [IDX_W-1:0] idx;

    assign idx = addr[IDX_W-1:0];
    // unsigned compare: wrapped negative addresses land far above LAST_WORD
    assign dmem_error = access && (addr > LAST_WORD);

    always_comb begin
        rd_data = '0;
        if (!dmem_error) begin
            for (int i = 0; i < 8; i++) begin
                rd_data[8*i +: 8] = mem[idx + IDX_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !dmem_error) begin
            for (int i = 0; i < 8; i++) begin
                mem[idx + IDX_W'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data-memory access selection
// and final stage status for writeback and forwarding.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_bubble,
    input  logic [3:0]  E_stat,
    input  logic [3:0]  E_icode,
    input  logic        e_Cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] E_valA,
    input  logic [3:0]  e_destE,
    input  logic [3:0]  E_dstM,
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat
);
    logic              access;
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       rd_data;
    logic              dmem_error;

    // ---- E -> M register boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n || M_bubble) begin
            M_stat  <= BUBBLE_STAT;
            M_icode <= BUBBLE_ICODE;
            M_Cnd   <= BUBBLE_CND;
            M_valE  <= BUBBLE_VAL;
            M_valA  <= BUBBLE_VAL;
            M_dstE  <= BUBBLE_DST;
            M_dstM  <= BUBBLE_DST;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_destE;
            M_dstM  <= E_dstM;
        end
    end

    // Instructions already faulted upstream never touch memory
    always_comb begin
        access = (M_stat == SAOK) && (mem_reads(M_icode) || mem_writes(M_icode));
        rd_en  = access && mem_reads(M_icode);
        wr_en  = access && mem_writes(M_icode) && rst_n;
        addr   = addr_from_vala(M_icode) ? ADDR_W'(M_valA) : ADDR_W'(M_valE);
    end

    data_memory #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_dmem (
        .clk        (clk),
        .access     (access),
        .wr_en      (wr_en),
        .addr       (addr),
        .wr_data    (M_valA),
        .rd_data    (rd_data),
        .dmem_error (dmem_error)
    );

    assign m_valM = (rd_en && !dmem_error) ? rd_data : 64'd0;
    assign m_stat = dmem_error ? SADR : M_stat;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer end of the execute-stage interface in the Y86-64 pipeline.
- Latches the execute-stage results (e_valE, e_Cnd, e_destE and the pass-through E_* fields) into the M pipeline register.
- Performs the data-memory access and produces m_valM and m_stat for the writeback register and for forwarding/hazard logic.
- The M-register fields are exported for forwarding to decode and for the CC-update gating in execute.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 64, address width. It equals the datapath word width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- M_bubble  in  1  load a bubble instead of the execute results.
- E_stat  in  4  status of the instruction in execute.
- E_icode  in  4  icode in execute.
- e_Cnd  in  1  condition result from execute.
- e_valE  in  64  ALU result.
- E_valA  in  64  store data / stack-read address / return address.
- e_destE  in  4  post-cmov destination for valE.
- E_dstM  in  4  destination for valM.
- M_stat  out  4  registered status.
- M_icode  out  4  registered icode.
- M_Cnd  out  1  registered condition.
- M_valE  out  64  registered ALU result.
- M_valA  out  64  registered valA.
- M_dstE  out  4  registered destE.
- M_dstM  out  4  registered dstM.
- m_valM  out  64  value read from memory; combinational.
- m_stat  out  4  final status of this stage; combinational.

Behaviour:
- Reset: when rst_n=0 at a clock edge, the M register loads a bubble:
  - M_icode=1 (nop), M_stat=1 (AOK), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=F, M_dstM=F.
  - Memory contents are not affected by reset.
  - No write occurs in the reset cycle.
- Register update:
  - At each edge with rst_n=1, M_bubble=1 loads the same bubble values as reset.
  - Otherwise the register loads {E_stat, E_icode, e_Cnd, e_valE, E_valA, e_destE, E_dstM}.
  - There is no stall input; the register always updates.
- Address select (from M_icode):
  - rmmovq(4), mrmovq(5), pushq(A), call(8): address = M_valE.
  - popq(B), ret(9): address = M_valA.
  - All other icodes: no access.
- Read: mrmovq, popq and ret read.
  - m_valM = 8 little-endian bytes at addr..addr+7, available combinationally in the same cycle.
  - m_valM=0 when there is no read or the access errors.
- Write: rmmovq, pushq and call write.
  - M_valA is written little-endian to addr..addr+7 at the rising edge that ends the cycle.
  - A write-then-read of the same address in the next cycle returns the new data.
- Range check: dmem_error=1 if the access is active and addr > MEM_BYTES-8.
  - The comparison is unsigned 64-bit, so a negative address is an error.
  - An erroring write modifies no byte.
- Status: m_stat = 3 (ADR) if dmem_error, else M_stat.
- Write gating: a write requires M_stat=AOK and rst_n=1.
  - An instruction already carrying HLT(2) or INS(4) does not access memory, and m_stat passes M_stat through.
- Simultaneous events:
  - Reset has priority over M_bubble.
  - The access in a cycle uses the M register contents of that cycle, independent of what is loading at the edge.

Decomposition:
- Package y86_pkg:
  - icode constants (NOP, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ).
  - stat codes SAOK=1, SHLT=2, SADR=3, SINS=4.
  - RNONE=4'hF.
  - The bubble field values.
- Sub-module data_memory:
  - Byte array, combinational 8-byte read, synchronous 8-byte write with write enable.
  - Range check and dmem_error output.
- memory_stage holds the M register, address/read/write select and status logic.

Test Plan:
1. Reset: rst_n=0 for 2 cycles, then 1 -> M_icode=1, M_stat=1, M_dstE=F, M_dstM=F, m_stat=1, and no memory write.
2. Store then load: rmmovq with e_valE=0x100, E_valA=0x1122334455667788; next cycle mrmovq with e_valE=0x100 -> m_valM=0x1122334455667788, and byte 0x100 reads 0x88.
3. Stack pair: pushq with e_valE=0x1F8, E_valA=0xDEAD; then popq with E_valA=0x1F8, E_dstM=3 -> m_valM=0xDEAD, M_dstM=3, m_stat=1.
4. Address error on load: mrmovq with e_valE=MEM_BYTES-4 -> m_stat=3 and m_valM=0.
5. Address error on store: rmmovq with e_valE=0xFFFFFFFFFFFFFFF8 -> m_stat=3; a subsequent read of address 0 and of the upper memory is unchanged.
6. Bubble priority: M_bubble=1 while E_icode=4 with valid operands -> M_icode=1, no write. Then E_stat=2 with E_icode=4 -> no write, and m_stat=2.
